// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared types and constants for the temperature BCD acquisition stage
package temp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int CONV_STEPS       = 7;
    localparam int DEFAULT_MAX_TEMP = 99;

    // Double-dabble correction: a digit of 5 or more would overflow on the next shift
    function automatic bcd_digit_t add3_ge5(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle double-dabble converter, 7-bit binary to two BCD digits
module bin2bcd_seq
    import temp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [7:0] bcd
);

    localparam logic [2:0] LAST_STEP = 3'(CONV_STEPS - 1);

    logic [6:0] shift_q;
    logic [7:0] bcd_q;
    logic [2:0] cnt_q;
    logic       busy_q;
    logic [7:0] bcd_adj;

    assign bcd_adj = {add3_ge5(bcd_q[7:4]), add3_ge5(bcd_q[3:0])};

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            shift_q <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
            if (cnt_q == LAST_STEP) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // Asserted during the final iteration so the parent can leave CONV on that same edge
    assign done = busy_q && (cnt_q == LAST_STEP);
    assign bcd  = bcd_q;

endmodule

// File: rtl/temp_bcd_acq.sv
// rtl/temp_bcd_acq.sv - two-channel temperature sample clamp and BCD conversion; TEMP_AVG_EN enables 4-sample averaging
module temp_bcd_acq
    import temp_pkg::*;
#(
    parameter int MAX_TEMP = DEFAULT_MAX_TEMP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       samp_valid,
    output logic       samp_ready,
    input  logic       samp_sel,
    input  logic [7:0] samp_data,
    output logic [7:0] Temp_amb,
    output logic [7:0] Temp_corp,
    output logic       upd,
    output logic       upd_sel
);

    localparam logic [7:0] MAX_T8 = 8'(MAX_TEMP);

    state_t     state_q;
    logic       sel_q;
    logic [7:0] data_q;
    logic [7:0] temp_amb_q;
    logic [7:0] temp_corp_q;
    logic       upd_q;
    logic       upd_sel_q;

    logic [6:0] clamp_x;
    logic [6:0] conv_bin;
    logic       conv_start;
    logic       conv_done;
    logic [7:0] conv_bcd;

    assign clamp_x    = (data_q > MAX_T8) ? MAX_T8[6:0] : data_q[6:0];
    assign conv_start = (state_q == LOAD);

`ifdef TEMP_AVG_EN
    logic [6:0] hist_q [2][4];
    logic [1:0] filled_q;
    logic [8:0] sum4;

    // The window is the new sample plus the three most recent history entries
    always_comb begin
        sum4 = '0;
        if (filled_q[sel_q]) begin
            sum4 = 9'(clamp_x) + 9'(hist_q[sel_q][0]) + 9'(hist_q[sel_q][1]) + 9'(hist_q[sel_q][2]);
        end else begin
            sum4 = {clamp_x, 2'b00};
        end
    end

    assign conv_bin = 7'((sum4 + 9'd2) >> 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            filled_q <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 4; i++) begin
                    hist_q[c][i] <= '0;
                end
            end
        end else if (state_q == LOAD) begin
            filled_q[sel_q] <= 1'b1;
            if (filled_q[sel_q]) begin
                hist_q[sel_q][3] <= hist_q[sel_q][2];
                hist_q[sel_q][2] <= hist_q[sel_q][1];
                hist_q[sel_q][1] <= hist_q[sel_q][0];
                hist_q[sel_q][0] <= clamp_x;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    hist_q[sel_q][i] <= clamp_x;
                end
            end
        end
    end
`else
    assign conv_bin = clamp_x;
`endif

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            data_q      <= '0;
            temp_amb_q  <= '0;
            temp_corp_q <= '0;
            upd_q       <= 1'b0;
            upd_sel_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (samp_valid) begin
                        sel_q   <= samp_sel;
                        data_q  <= samp_data;
                        state_q <= LOAD;
                    end
                end
                LOAD: state_q <= CONV;
                CONV: begin
                    if (conv_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (sel_q) begin
                        temp_corp_q <= conv_bcd;
                    end else begin
                        temp_amb_q <= conv_bcd;
                    end
                    upd_q     <= 1'b1;
                    upd_sel_q <= sel_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign samp_ready = (state_q == IDLE) && !reset;
    assign Temp_amb   = temp_amb_q;
    assign Temp_corp  = temp_corp_q;
    assign upd        = upd_q;
    assign upd_sel    = upd_sel_q;

endmodule

// File: doc/temp_bcd_acq.md
# temp_bcd_acq

Sequential acquisition stage that sits directly upstream of the alarm/ventilation comparator. It accepts raw binary temperature samples (°C) for two channels, ambient and body, over a valid/ready handshake. Each sample is clamped to 0..99 and converted to two-digit packed BCD by a multi-cycle double-dabble engine. The results are held in registered `Temp_amb` / `Temp_corp` outputs, which the comparator reads, with tens in [7:4] and units in [3:0].

## Interface
Parameters:
- `MAX_TEMP`, default 99: clamp ceiling in °C; must be ≤ 99.

Ports:
- `clk` in 1: single system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `samp_valid` in 1: sample offered this cycle.
- `samp_ready` out 1: block can accept a sample this cycle.
- `samp_sel` in 1: 0 = ambient channel, 1 = body channel.
- `samp_data` in 8: unsigned binary temperature, °C.
- `Temp_amb` out 8: packed BCD ambient temperature, registered.
- `Temp_corp` out 8: packed BCD body temperature, registered.
- `upd` out 1: one-cycle pulse when either output register changes.
- `upd_sel` out 1: channel written at the last `upd`; holds its value between pulses.

## Operation
- Transfer occurs on a rising edge where `samp_valid & samp_ready` is true. `samp_sel` and `samp_data` are captured on that edge.
- `samp_ready` = (state == IDLE) & ~`reset`. `samp_valid` outside IDLE is ignored and not queued. The source must hold valid/data until the transfer completes.
- FSM states:
  - IDLE → LOAD on transfer.
  - LOAD: clamp, `x = (data > MAX_TEMP) ? MAX_TEMP : data`. Load the 7-bit x into the shift register and clear the BCD register. → CONV.
  - CONV: 7 iterations. Each iteration adds 3 to any BCD digit ≥ 5, then shifts left 1. A 3-bit iteration counter counts 0..6. → DONE after iteration 6.
  - DONE: write the BCD result into the register selected by the captured `samp_sel`. Pulse `upd` and set `upd_sel`. → IDLE.
- Only the selected channel register is written. The other channel holds its value.
- Arithmetic: clamp compares the full 8 bits. Values 100..255 produce 8'h99. A value of 0 produces 8'h00. BCD digits never exceed 9.
- Reset values: `Temp_amb` = 8'h00, `Temp_corp` = 8'h00, `upd` = 0, `upd_sel` = 0, state = IDLE, counter = 0.
- Reset mid-operation, in any state, aborts the conversion. The captured sample is discarded, no `upd` is issued, and outputs return to 00 on the same edge.

## Timing
- Edge E0: transfer. E1: LOAD→CONV. E2..E8: 7 CONV iterations. E8: CONV→DONE.
- Edge E9: output register written and `upd` registered high. The new value and `upd` are visible in the cycle after E9, which is also the cycle in which `samp_ready` returns to 1.
- Latency from transfer edge to visible output: 9 clock edges. Maximum throughput: one sample per 10 cycles.
- A held `samp_valid` is accepted on the first IDLE cycle. That can be the same cycle `upd` is high.
- Outputs change only on the DONE edge or the reset edge. There is no combinational path from inputs to `Temp_amb` / `Temp_corp`.

## Configuration
- Macro `TEMP_AVG_EN`.
- Defined:
  - Each channel keeps a 4-entry history of clamped samples.
  - The value converted is `(sum4 + 2) >> 2`, a 9-bit sum with rounding; the result is always ≤ `MAX_TEMP`.
  - History shifts in during LOAD. Averaging adds no extra cycle; the divide is combinational in LOAD.
  - The first sample after reset on a channel fills all 4 history entries.
  - Reset clears the histories and the per-channel "filled" flags.
- Undefined: no history registers. The clamped sample is converted directly.

## Structure
- Shared package `temp_pkg`: FSM state enum (IDLE, LOAD, CONV, DONE), `CONV_STEPS` = 7, BCD-digit type (4 bits), default `MAX_TEMP` constant.
- Sub-module `bin2bcd_seq`:
  - Owns the shift register, iteration counter, and add-3 logic.
  - Interface: `start`, 7-bit `bin`, `done`, 8-bit `bcd`.
  - Reused by the parent FSM.
- Averaging logic stays in the top level under `TEMP_AVG_EN`.

## Test plan
- Reset held 3 cycles, then released → `Temp_amb` = 8'h00, `Temp_corp` = 8'h00, `upd` = 0, `samp_ready` = 1 on the first cycle after release.
- Ambient sample `samp_sel`=0, `samp_data`=25 → after 9 edges `Temp_amb` = 8'h25, `upd` one cycle with `upd_sel`=0, `Temp_corp` unchanged at 8'h00.
- Body samples 38, then 120 → `Temp_corp` = 8'h38, then 8'h99 (clamp). Boundary values 99 → 8'h99, 100 → 8'h99, 0 → 8'h00.
- `samp_valid` held continuously with data 30 on ambient → `samp_ready` low for cycles 1..9. A new transfer occurs exactly on the cycle after `upd`, and exactly one `upd` is produced per 10 cycles.
- Reset asserted on the 5th cycle after a body transfer of 40 → `Temp_corp` stays 8'h00, no `upd` pulse, `samp_ready` = 1 after release.
- With `TEMP_AVG_EN`, body samples 36, 36, 36, 40 → outputs 8'h36, 8'h36, 8'h36, 8'h37 (rounding check: sum 148 → 37). Without the macro, the same stimulus → 8'h36, 8'h36, 8'h36, 8'h40.
